// File: rtl/axis_alu_arbiter_pkg.sv
// Shared types and helpers for the AxisALU requester arbiter.
package axis_alu_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_grant.sv
// Combinational round-robin picker: first requester strictly after rr_ptr, wrapping.
module axis_rr_grant #(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [IDX_W-1:0]    grant,
    output logic                any_req
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant   = rr_ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            idx = IDX_W'((int'(rr_ptr) + i) % CHANNELS);
            if (req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_alu_arbiter.sv
// Shares one AxisALU among CHANNELS AXI-Stream requesters: packet-locked round-robin
// on the operand side, tid-based demux on the result side.
module axis_alu_arbiter
    import axis_alu_arbiter_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int OP0_WIDTH   = 16,
    parameter int OP1_WIDTH   = 16,
    parameter int RSLT_WIDTH  = OP0_WIDTH + OP1_WIDTH - 1,
    parameter int ID_WIDTH    = 8,
    parameter bit LAST_ENABLE = 1'b1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [CHANNELS*OP0_WIDTH-1:0]  s_axis_tdata_op0,
    input  logic [CHANNELS*OP1_WIDTH-1:0]  s_axis_tdata_op1,
    input  logic [CHANNELS-1:0]            s_axis_tlast,
    input  logic [CHANNELS-1:0]            s_axis_tvalid,
    output logic [CHANNELS-1:0]            s_axis_tready,
    output logic [OP0_WIDTH-1:0]           m_alu_tdata_op0,
    output logic [OP1_WIDTH-1:0]           m_alu_tdata_op1,
    output logic                           m_alu_tlast,
    output logic [ID_WIDTH-1:0]            m_alu_tid,
    output logic                           m_alu_tvalid,
    input  logic                           m_alu_tready,
    input  logic [RSLT_WIDTH-1:0]          s_alu_tdata,
    input  logic                           s_alu_tlast,
    input  logic [ID_WIDTH-1:0]            s_alu_tid,
    input  logic                           s_alu_tvalid,
    output logic                           s_alu_tready,
    output logic [CHANNELS*RSLT_WIDTH-1:0] m_axis_tdata,
    output logic [CHANNELS-1:0]            m_axis_tlast,
    output logic [CHANNELS-1:0]            m_axis_tvalid,
    input  logic [CHANNELS-1:0]            m_axis_tready,
    output logic                           tid_err
);

    localparam int IDX_W = idx_width(CHANNELS);
    localparam logic [ID_WIDTH:0] TID_LIM = (ID_WIDTH + 1)'(CHANNELS);

    if (ID_WIDTH < IDX_W) begin : g_id_width_check
        $error("axis_alu_arbiter: ID_WIDTH too small for CHANNELS");
    end

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] grant_idx, rr_ptr, rr_pick;
    logic             any_req;

    logic                 sel_vld_p0, sel_last_p0, accept_p0, pkt_end_p0, fwd_rdy;
    logic [OP0_WIDTH-1:0] sel_op0_p0;
    logic [OP1_WIDTH-1:0] sel_op1_p0;

    logic                 out_vld_p1, out_last_p1, skid_vld_p1, skid_last_p1;
    logic [OP0_WIDTH-1:0] out_op0_p1, skid_op0_p1;
    logic [OP1_WIDTH-1:0] out_op1_p1, skid_op1_p1;
    logic [IDX_W-1:0]     out_tid_p1, skid_tid_p1;

    axis_rr_grant #(.CHANNELS(CHANNELS), .IDX_W(IDX_W)) u_rr_grant (
        .req     (s_axis_tvalid),
        .rr_ptr  (rr_ptr),
        .grant   (rr_pick),
        .any_req (any_req)
    );

    // Stage p0: granted requester selected and offered to the skid stage.
    always_comb begin
        sel_vld_p0    = 1'b0;
        sel_last_p0   = 1'b0;
        sel_op0_p0    = '0;
        sel_op1_p0    = '0;
        s_axis_tready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                sel_vld_p0       = s_axis_tvalid[k];
                sel_last_p0      = s_axis_tlast[k];
                sel_op0_p0       = s_axis_tdata_op0[k*OP0_WIDTH +: OP0_WIDTH];
                sel_op1_p0       = s_axis_tdata_op1[k*OP1_WIDTH +: OP1_WIDTH];
                s_axis_tready[k] = (state == ARB_LOCK) && fwd_rdy;
            end
        end
    end

    assign fwd_rdy    = !skid_vld_p1;
    assign accept_p0  = (state == ARB_LOCK) && sel_vld_p0 && fwd_rdy;
    assign pkt_end_p0 = accept_p0 && (sel_last_p0 || !LAST_ENABLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (any_req)    state_nxt = ARB_LOCK;
            ARB_LOCK: if (pkt_end_p0) state_nxt = ARB_IDLE;
            default:                  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ARB_IDLE;
            grant_idx <= '0;
            rr_ptr    <= IDX_W'(CHANNELS - 1);
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && any_req) grant_idx <= rr_pick;
            if (pkt_end_p0)                   rr_ptr    <= grant_idx;
        end
    end

    // Stage p1: output register plus one skid entry; upstream ready depends only on skid occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (!out_vld_p1 || m_alu_tready) begin
            out_vld_p1  <= skid_vld_p1 || accept_p0;
            skid_vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            skid_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!out_vld_p1 || m_alu_tready) begin
            if (skid_vld_p1) begin
                out_op0_p1  <= skid_op0_p1;
                out_op1_p1  <= skid_op1_p1;
                out_last_p1 <= skid_last_p1;
                out_tid_p1  <= skid_tid_p1;
            end else if (accept_p0) begin
                out_op0_p1  <= sel_op0_p0;
                out_op1_p1  <= sel_op1_p0;
                out_last_p1 <= sel_last_p0;
                out_tid_p1  <= grant_idx;
            end
        end else if (accept_p0) begin
            skid_op0_p1  <= sel_op0_p0;
            skid_op1_p1  <= sel_op1_p0;
            skid_last_p1 <= sel_last_p0;
            skid_tid_p1  <= grant_idx;
        end
    end

    assign m_alu_tvalid    = out_vld_p1;
    assign m_alu_tdata_op0 = out_op0_p1;
    assign m_alu_tdata_op1 = out_op1_p1;
    assign m_alu_tlast     = out_last_p1;
    assign m_alu_tid       = ID_WIDTH'(out_tid_p1);

    // Result side: combinational demux; unknown tags are swallowed.
    always_comb begin
        m_axis_tvalid = '0;
        s_alu_tready  = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (s_alu_tid == ID_WIDTH'(k)) begin
                m_axis_tvalid[k] = s_alu_tvalid;
                s_alu_tready     = m_axis_tready[k];
            end
        end
    end

    assign m_axis_tdata = {CHANNELS{s_alu_tdata}};
    assign m_axis_tlast = {CHANNELS{s_alu_tlast}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tid_err <= 1'b0;
        else if (s_alu_tvalid && ({1'b0, s_alu_tid} >= TID_LIM))
            tid_err <= 1'b1;
    end

endmodule

// File: tb/tb_axis_alu_arbiter.sv
// Directed bench for axis_alu_arbiter with an in-order scoreboard on the ALU operand port.
module tb_axis_alu_arbiter;

    localparam int CH = 4;
    localparam int OW = 16;
    localparam int RW = 31;
    localparam int IW = 8;

    typedef struct packed {
        logic [IW-1:0] tid;
        logic [OW-1:0] op0;
        logic [OW-1:0] op1;
        logic          last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rstn;
    logic [CH*OW-1:0]   s_axis_tdata_op0, s_axis_tdata_op1;
    logic [CH-1:0]      s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [OW-1:0]      m_alu_tdata_op0, m_alu_tdata_op1;
    logic               m_alu_tlast, m_alu_tvalid, m_alu_tready;
    logic [IW-1:0]      m_alu_tid;
    logic [RW-1:0]      s_alu_tdata;
    logic               s_alu_tlast, s_alu_tvalid, s_alu_tready;
    logic [IW-1:0]      s_alu_tid;
    logic [CH*RW-1:0]   m_axis_tdata;
    logic [CH-1:0]      m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic               tid_err;

    axis_alu_arbiter #(
        .CHANNELS(CH), .OP0_WIDTH(OW), .OP1_WIDTH(OW), .RSLT_WIDTH(RW),
        .ID_WIDTH(IW), .LAST_ENABLE(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata_op0(s_axis_tdata_op0), .s_axis_tdata_op1(s_axis_tdata_op1),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_alu_tdata_op0(m_alu_tdata_op0), .m_alu_tdata_op1(m_alu_tdata_op1),
        .m_alu_tlast(m_alu_tlast), .m_alu_tid(m_alu_tid), .m_alu_tvalid(m_alu_tvalid),
        .m_alu_tready(m_alu_tready),
        .s_alu_tdata(s_alu_tdata), .s_alu_tlast(s_alu_tlast), .s_alu_tid(s_alu_tid),
        .s_alu_tvalid(s_alu_tvalid), .s_alu_tready(s_alu_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .tid_err(tid_err)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t src_q[CH][$];
    beat_t exp_q[$];
    int    xfer_t[$];
    int    tid_cnt[CH];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int ch, input logic [OW-1:0] op0, input logic [OW-1:0] op1,
                            input logic last);
        beat_t b;
        b.tid  = IW'(ch);
        b.op0  = op0;
        b.op1  = op1;
        b.last = last;
        src_q[ch].push_back(b);
        exp_q.push_back(b);
    endtask

    function automatic int src_pending();
        int n = 0;
        for (int k = 0; k < CH; k++) n += src_q[k].size();
        return n;
    endfunction

    task automatic drain(input string tag, input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || src_pending() != 0) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Requester models: present the head of each source queue, pop on handshake.
    initial begin
        logic [CH-1:0] acc;
        s_axis_tvalid    = '0;
        s_axis_tlast     = '0;
        s_axis_tdata_op0 = '0;
        s_axis_tdata_op1 = '0;
        forever begin
            @(negedge clk);
            acc = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            for (int k = 0; k < CH; k++) begin
                if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    s_axis_tvalid[k]              = 1'b1;
                    s_axis_tlast[k]               = src_q[k][0].last;
                    s_axis_tdata_op0[k*OW +: OW]  = src_q[k][0].op0;
                    s_axis_tdata_op1[k*OW +: OW]  = src_q[k][0].op1;
                end else begin
                    s_axis_tvalid[k] = 1'b0;
                end
            end
        end
    end

    // ALU-port monitor: scoreboard compare on every transfer, stability while stalled.
    beat_t held;
    logic  stalled = 1'b0;
    always @(negedge clk) begin
        beat_t obs, e;
        obs = '{tid: m_alu_tid, op0: m_alu_tdata_op0, op1: m_alu_tdata_op1, last: m_alu_tlast};
        if (rstn && stalled) chk("alu_hold_stable", 64'(obs), 64'(held));
        if (rstn && m_alu_tvalid && m_alu_tready) begin
            xfer_t.push_back(cyc);
            if (m_alu_tid < IW'(CH)) tid_cnt[m_alu_tid[1:0]]++;
            if (exp_q.size() == 0) begin
                chk("alu_unexpected_beat", 64'(obs), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("alu_beat", 64'(obs), 64'(e));
            end
        end
        stalled = rstn && m_alu_tvalid && !m_alu_tready;
        held    = obs;
    end

    initial begin
        logic [3:0] pat;
        rstn          = 1'b0;
        m_alu_tready  = 1'b1;
        s_alu_tdata   = '0;
        s_alu_tlast   = 1'b0;
        s_alu_tid     = '0;
        s_alu_tvalid  = 1'b0;
        m_axis_tready = '1;
        for (int k = 0; k < CH; k++) tid_cnt[k] = 0;

        // Reset with every requester valid.
        for (int k = 0; k < CH; k++) push_pkt(k, OW'(16'h0100 + k), OW'(k), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_alu_tvalid), 64'd0);
        chk("rst_tid_err", 64'(tid_err), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("first_grant_ready", 64'(s_axis_tready), 64'b0001);
        chk("first_no_beat_yet", 64'(m_alu_tvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("first_beat_valid", 64'(m_alu_tvalid), 64'd1);
        chk("first_beat_tid", 64'(m_alu_tid), 64'd0);
        drain("drain_reset_order", 100);

        // Two 3-beat packets: ch0 then ch2, one idle cycle between them.
        xfer_t.delete();
        for (int i = 1; i <= 3; i++) push_pkt(0, OW'(i), 16'd2, i == 3);
        for (int i = 1; i <= 3; i++) push_pkt(2, OW'(i), 16'd2, i == 3);
        drain("drain_two_pkts", 100);
        chk("pkt0_back_to_back", 64'(xfer_t[2] - xfer_t[0]), 64'd2);
        chk("pkt2_back_to_back", 64'(xfer_t[5] - xfer_t[3]), 64'd2);
        chk("inter_pkt_gap", 64'(xfer_t[3] - xfer_t[2]), 64'd2);

        // 100 one-beat packets, all requesters valid; rr pointer now sits at 2.
        for (int k = 0; k < CH; k++) tid_cnt[k] = 0;
        for (int p = 0; p < 25; p++)
            for (int j = 0; j < CH; j++)
                push_pkt((3 + j) % CH, OW'(p), OW'((3 + j) % CH), 1'b1);
        drain("drain_fairness", 1000);
        for (int k = 0; k < CH; k++) chk($sformatf("share_ch%0d", k), 64'(tid_cnt[k]), 64'd25);

        // Backpressure 1,0,0,1 from the ALU in the middle of a 6-beat packet.
        pat = 4'b1001;
        for (int i = 0; i < 6; i++) push_pkt(1, OW'(16'h0040 + i), ~OW'(i), i == 5);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            m_alu_tready = pat[3 - (i % 4)];
        end
        m_alu_tready = 1'b1;
        drain("drain_backpressure", 200);

        // Result demux: ch1 blocked, then released, then ch3.
        @(posedge clk);
        #1;
        m_axis_tready = 4'b1101;
        s_alu_tdata   = 31'h1234_5678;
        s_alu_tlast   = 1'b1;
        s_alu_tid     = 8'd1;
        s_alu_tvalid  = 1'b1;
        #1;
        chk("res1_blocked_ready", 64'(s_alu_tready), 64'd0);
        chk("res1_valid", 64'(m_axis_tvalid), 64'b0010);
        chk("res1_data", 64'(m_axis_tdata[1*RW +: RW]), 64'h1234_5678);
        chk("res1_last", 64'(m_axis_tlast[1]), 64'd1);
        @(posedge clk);
        #1;
        chk("res1_held", 64'(m_axis_tvalid), 64'b0010);
        m_axis_tready = 4'b1111;
        #1;
        chk("res1_released_ready", 64'(s_alu_tready), 64'd1);
        @(posedge clk);
        #1;
        s_alu_tid   = 8'd3;
        s_alu_tdata = 31'h0BAD_F00D;
        s_alu_tlast = 1'b0;
        #1;
        chk("res3_valid", 64'(m_axis_tvalid), 64'b1000);
        chk("res3_data", 64'(m_axis_tdata[3*RW +: RW]), 64'h0BAD_F00D);
        chk("res3_ready", 64'(s_alu_tready), 64'd1);
        chk("tid_err_clean", 64'(tid_err), 64'd0);

        // Out-of-range tag: swallowed, sticky error.
        @(posedge clk);
        #1;
        s_alu_tid = 8'd7;
        #1;
        chk("bad_tid_ready", 64'(s_alu_tready), 64'd1);
        chk("bad_tid_no_valid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk);
        #1;
        s_alu_tvalid = 1'b0;
        chk("tid_err_set", 64'(tid_err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("tid_err_sticky", 64'(tid_err), 64'd1);
        rstn = 1'b0;
        #1;
        chk("tid_err_cleared", 64'(tid_err), 64'd0);
        chk("rst_again_tvalid", 64'(m_alu_tvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout checks=%0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
